// File: rtl/rx_frame_pkg.sv
// Shared definitions for the rx frame recorder: FSM state encoding,
// frame-info word field widths/offsets and a packing helper.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_RECV  = 3'b010,
        ST_CLOSE = 3'b100
    } state_t;

    localparam int INFO_CNT_W = 12;
    localparam int INFO_MS_W  = 12;
    localparam int INFO_ACQ_W = 4;
    localparam int INFO_W     = INFO_CNT_W + INFO_MS_W + INFO_ACQ_W;

    localparam int ACQ_LSB = 0;
    localparam int MS_LSB  = ACQ_LSB + INFO_ACQ_W;
    localparam int CNT_LSB = MS_LSB + INFO_MS_W;

    localparam logic [15:0] GAP_MAX = 16'hFFFF;

    // frame_info = {byte count, ms stamp, 0.1 ms stamp}
    function automatic logic [INFO_W-1:0] packInfo(
        input logic [INFO_CNT_W-1:0] cnt,
        input logic [INFO_MS_W-1:0]  ms,
        input logic [INFO_ACQ_W-1:0] acq
    );
        logic [INFO_W-1:0] w;
        w = '0;
        w[CNT_LSB +: INFO_CNT_W] = cnt;
        w[MS_LSB  +: INFO_MS_W]  = ms;
        w[ACQ_LSB +: INFO_ACQ_W] = acq;
        return w;
    endfunction

endpackage

// File: rtl/rx_frame_recorder_fifo.sv
// frame_info_fifo: first-word-fall-through register-array FIFO for the
// frame-info words.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   n_we       active-low push (ignored when full unless a pop happens too)
//   n_re       active-low pop (ignored when empty)
//   n_clr      active-low synchronous clear, wins over push/pop
//   dIn        word to push
//   dOut       head word, 0 when empty
//   count      entries held, 0..DEPTH
//   full/empty status flags
module frame_info_fifo
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INFO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_we,
    input  logic             n_re,
    input  logic             n_clr,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] dOut,
    output logic [6:0]       count,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty = (count == 7'd0);
    assign full  = (count == 7'(DEPTH));
    assign doPop = !n_re && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign doPush = !n_we && (!full || doPop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (!n_clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (doPush && n_clr) mem[wrPtr] <= dIn;
    end

    assign dOut = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/rx_frame_recorder.sv
// rx_frame_recorder: watches bytes written into the rx data FIFO, splits
// them into frames on an idle gap counted in AcqSig ticks, and queues one
// frame-info word per closed frame for the CPU.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   p_Enable_i               block enable; low drops any open frame
//   n_Clr_i                  active-low clear of info FIFO, open frame, overflow flag
//   p_ByteWr_i               one pulse per received byte
//   AcqSig_i                 acquisition tick used for gap timing
//   FrameGapSet_i            closing gap in ticks (0 behaves as 1)
//   acqurate_stamp_i         0.1 ms stamp of the current byte
//   millisecond_stamp_i      ms stamp of the current byte
//   n_RxFrameInfo_Rd_i       active-low pop of the info FIFO
//   RxFrameInfo_o            head info word {count, ms, acq}, 0 when empty
//   p_RxFrame_Empty_o/Full_o info FIFO status
//   FrameNum_o               entries held
//   p_FrameOver_o            sticky: a closed frame was lost to a full FIFO
module rx_frame_recorder
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_Enable_i,
    input  logic        n_Clr_i,
    input  logic        p_ByteWr_i,
    input  logic        AcqSig_i,
    input  logic [15:0] FrameGapSet_i,
    input  logic [3:0]  acqurate_stamp_i,
    input  logic [11:0] millisecond_stamp_i,
    input  logic        n_RxFrameInfo_Rd_i,
    output logic [27:0] RxFrameInfo_o,
    output logic        p_RxFrame_Empty_o,
    output logic        p_RxFrame_Full_o,
    output logic [6:0]  FrameNum_o,
    output logic        p_FrameOver_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] byteCnt;
    logic [15:0]      gapCnt;
    logic [11:0]      msLat;
    logic [3:0]       acqLat;
    logic [15:0]      gapLimit;
    logic             byteIn;
    logic             gapExpired;
    logic             closing;
    logic             fifoFull;

    assign byteIn   = p_ByteWr_i && p_Enable_i;
    assign gapLimit = (FrameGapSet_i == 16'd0) ? 16'd1 : FrameGapSet_i;
    // Expiry is judged on the tick that would bring GapCnt to the limit; a
    // byte in the same cycle keeps the frame open.
    assign gapExpired = AcqSig_i && !p_ByteWr_i &&
                        (({1'b0, gapCnt} + 17'd1) >= {1'b0, gapLimit});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        closing   = 1'b0;
        unique case (state)
            ST_IDLE:  if (byteIn) nextState = ST_RECV;
            ST_RECV:  if (gapExpired) nextState = ST_CLOSE;
            ST_CLOSE: begin
                closing   = 1'b1;
                nextState = byteIn ? ST_RECV : ST_IDLE;
            end
            default:  nextState = ST_IDLE;
        endcase
        if (!p_Enable_i || !n_Clr_i) begin
            nextState = ST_IDLE;
            closing   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteCnt <= '0;
            gapCnt  <= '0;
            msLat   <= '0;
            acqLat  <= '0;
        end else if (!n_Clr_i || !p_Enable_i) begin
            byteCnt <= '0;
            gapCnt  <= '0;
        end else if (byteIn) begin
            msLat  <= millisecond_stamp_i;
            acqLat <= acqurate_stamp_i;
            gapCnt <= '0;
            // Only an already open frame accumulates; IDLE and CLOSE start fresh.
            if (state == ST_RECV)
                byteCnt <= (byteCnt == CNT_MAX) ? byteCnt : byteCnt + 1'b1;
            else
                byteCnt <= CNT_W'(1);
        end else begin
            if (state == ST_CLOSE) begin
                byteCnt <= '0;
                gapCnt  <= '0;
            end else if (state == ST_RECV && AcqSig_i && gapCnt != GAP_MAX) begin
                gapCnt <= gapCnt + 1'b1;
            end
        end
    end

    // A pop alongside the close makes room, so that case is not an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            p_FrameOver_o <= 1'b0;
        else if (!n_Clr_i)
            p_FrameOver_o <= 1'b0;
        else if (closing && fifoFull && n_RxFrameInfo_Rd_i)
            p_FrameOver_o <= 1'b1;
    end

    frame_info_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(INFO_W)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .n_we  (!closing),
        .n_re  (n_RxFrameInfo_Rd_i),
        .n_clr (n_Clr_i),
        .dIn   (packInfo(byteCnt, msLat, acqLat)),
        .dOut  (RxFrameInfo_o),
        .count (FrameNum_o),
        .full  (fifoFull),
        .empty (p_RxFrame_Empty_o)
    );

    assign p_RxFrame_Full_o = fifoFull;

endmodule

// File: tb/tb_rx_frame_recorder.sv
// Self-checking bench for rx_frame_recorder: directed scenarios followed by
// randomized frames, compared against a queue-based model of the info FIFO.
module tb_rx_frame_recorder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_Enable_i;
    logic        n_Clr_i;
    logic        p_ByteWr_i;
    logic        AcqSig_i;
    logic [15:0] FrameGapSet_i;
    logic [3:0]  acqurate_stamp_i;
    logic [11:0] millisecond_stamp_i;
    logic        n_RxFrameInfo_Rd_i;
    logic [27:0] RxFrameInfo_o;
    logic        p_RxFrame_Empty_o;
    logic        p_RxFrame_Full_o;
    logic [6:0]  FrameNum_o;
    logic        p_FrameOver_o;

    always #5 clk = ~clk;

    rx_frame_recorder #(.DEPTH(DEPTH), .CNT_W(12)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .p_Enable_i          (p_Enable_i),
        .n_Clr_i             (n_Clr_i),
        .p_ByteWr_i          (p_ByteWr_i),
        .AcqSig_i            (AcqSig_i),
        .FrameGapSet_i       (FrameGapSet_i),
        .acqurate_stamp_i    (acqurate_stamp_i),
        .millisecond_stamp_i (millisecond_stamp_i),
        .n_RxFrameInfo_Rd_i  (n_RxFrameInfo_Rd_i),
        .RxFrameInfo_o       (RxFrameInfo_o),
        .p_RxFrame_Empty_o   (p_RxFrame_Empty_o),
        .p_RxFrame_Full_o    (p_RxFrame_Full_o),
        .FrameNum_o          (FrameNum_o),
        .p_FrameOver_o       (p_FrameOver_o)
    );

    int          total = 0;
    int          bad   = 0;
    logic [27:0] expQ[$];
    logic        expOver = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] infoWord(input int nBytes, input int ms, input int acq);
        int c;
        c = (nBytes > 4095) ? 4095 : nBytes;
        return {c[11:0], ms[11:0], acq[3:0]};
    endfunction

    task automatic modelClose(input logic [27:0] w, input bit popSame);
        if (popSame && expQ.size() > 0) void'(expQ.pop_front());
        if (expQ.size() < DEPTH) expQ.push_back(w);
        else                     expOver = 1'b1;
    endtask

    task automatic checkAll(input string tag);
        logic [27:0] head;
        head = (expQ.size() > 0) ? expQ[0] : 28'd0;
        chk({tag, ".num"},   32'(FrameNum_o),        32'(expQ.size()));
        chk({tag, ".empty"}, 32'(p_RxFrame_Empty_o), 32'(expQ.size() == 0));
        chk({tag, ".full"},  32'(p_RxFrame_Full_o),  32'(expQ.size() == DEPTH));
        chk({tag, ".head"},  32'(RxFrameInfo_o),     32'(head));
        chk({tag, ".over"},  32'(p_FrameOver_o),     32'(expOver));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input int ms, input int acq);
        p_ByteWr_i          = 1'b1;
        millisecond_stamp_i = ms[11:0];
        acqurate_stamp_i    = acq[3:0];
        cyc();
        p_ByteWr_i = 1'b0;
    endtask

    task automatic acqTick();
        AcqSig_i = 1'b1;
        cyc();
        AcqSig_i = 1'b0;
        cyc();
    endtask

    task automatic popOne();
        n_RxFrameInfo_Rd_i = 1'b0;
        cyc();
        n_RxFrameInfo_Rd_i = 1'b1;
        if (expQ.size() > 0) void'(expQ.pop_front());
    endtask

    task automatic clearAll();
        n_Clr_i = 1'b0;
        cyc();
        n_Clr_i = 1'b1;
        expQ.delete();
        expOver = 1'b0;
    endtask

    // One-byte frame, closed by a single tick (gap setting must be 0 or 1).
    task automatic shortFrame(input int ms, input int acq);
        sendByte(ms, acq);
        acqTick();
        modelClose(infoWord(1, ms, acq), 1'b0);
    endtask

    initial begin
        int ms;
        int acq;
        rst                 = 1'b0;
        p_Enable_i          = 1'b1;
        n_Clr_i             = 1'b1;
        p_ByteWr_i          = 1'b0;
        AcqSig_i            = 1'b0;
        FrameGapSet_i       = 16'd10;
        acqurate_stamp_i    = 4'd0;
        millisecond_stamp_i = 12'd0;
        n_RxFrameInfo_Rd_i  = 1'b1;
        ms  = 0;
        acq = 0;

        repeat (2) cyc();
        checkAll("reset");
        rst = 1'b1;
        cyc();

        // Basic frame: 5 bytes 3 ticks apart, closes on the 10th idle tick.
        for (int b = 0; b < 5; b++) begin
            sendByte((b == 4) ? 123 : 100 + b, (b == 4) ? 7 : b);
            if (b < 4) repeat (3) acqTick();
        end
        repeat (9) acqTick();
        checkAll("t1.open");
        acqTick();
        modelClose(infoWord(5, 123, 7), 1'b0);
        chk("t1.word", 32'(RxFrameInfo_o), 32'h0050_7B7);
        checkAll("t1.closed");
        popOne();
        checkAll("t1.popped");

        // Byte coinciding with the expiring tick keeps the frame open.
        sendByte(200, 1);
        repeat (9) acqTick();
        p_ByteWr_i = 1'b1; AcqSig_i = 1'b1;
        millisecond_stamp_i = 12'd201; acqurate_stamp_i = 4'd2;
        cyc();
        p_ByteWr_i = 1'b0; AcqSig_i = 1'b0;
        cyc();
        checkAll("t2.held");
        repeat (9) acqTick();
        checkAll("t2.open");
        acqTick();
        modelClose(infoWord(2, 201, 2), 1'b0);
        checkAll("t2.closed");
        popOne();

        // Overflow: 9 frames into an 8-deep FIFO, gap setting 0 acts as 1.
        FrameGapSet_i = 16'd0;
        for (int i = 1; i <= 9; i++) shortFrame(i, i);
        checkAll("t3.full");
        chk("t3.headWord", 32'(RxFrameInfo_o), 32'h0010011);
        popOne();
        checkAll("t3.pop");
        chk("t3.head2", 32'(RxFrameInfo_o), 32'h0010022);
        clearAll();
        checkAll("t3.clr");

        // Full FIFO: pop in the same cycle as a close -> no overflow.
        for (int i = 20; i < 28; i++) shortFrame(i, i - 20);
        checkAll("t4.full");
        sendByte(30, 3);
        AcqSig_i = 1'b1;
        cyc();
        AcqSig_i = 1'b0;
        n_RxFrameInfo_Rd_i = 1'b0;
        cyc();
        n_RxFrameInfo_Rd_i = 1'b1;
        modelClose(infoWord(1, 30, 3), 1'b1);
        checkAll("t4.pushpop");
        repeat (DEPTH) begin
            popOne();
            checkAll("t4.drain");
        end
        popOne();
        checkAll("t4.emptyPop");

        // Clear with three entries stored.
        for (int i = 40; i < 43; i++) shortFrame(i, i - 40);
        checkAll("t5.three");
        clearAll();
        checkAll("t5.clr");

        // Byte count saturation.
        FrameGapSet_i       = 16'd1;
        millisecond_stamp_i = 12'd999;
        acqurate_stamp_i    = 4'd9;
        p_ByteWr_i          = 1'b1;
        repeat (4100) cyc();
        p_ByteWr_i = 1'b0;
        acqTick();
        modelClose(infoWord(4100, 999, 9), 1'b0);
        chk("t6.satCnt", 32'(RxFrameInfo_o[27:16]), 32'hFFF);
        checkAll("t6.sat");
        popOne();

        // Enable low discards the open frame and ignores bytes.
        FrameGapSet_i = 16'd3;
        sendByte(300, 3);
        sendByte(301, 4);
        p_Enable_i = 1'b0;
        cyc();
        p_Enable_i = 1'b1;
        repeat (5) acqTick();
        checkAll("t7.dropped");
        p_Enable_i = 1'b0;
        sendByte(302, 5);
        p_Enable_i = 1'b1;
        repeat (5) acqTick();
        checkAll("t7.ignored");

        // Asynchronous reset mid-frame with entries stored.
        FrameGapSet_i = 16'd0;
        shortFrame(50, 1);
        shortFrame(51, 2);
        FrameGapSet_i = 16'd10;
        for (int b = 0; b < 3; b++) sendByte(60 + b, b);
        #2 rst = 1'b0;
        #1;
        expQ.delete();
        expOver = 1'b0;
        checkAll("t8.async");
        cyc();
        cyc();
        rst = 1'b1;
        repeat (12) acqTick();
        checkAll("t8.silent");

        // Randomized frames with random pops.
        for (int f = 0; f < 24; f++) begin
            int gap;
            int nb;
            gap = $urandom_range(6, 2);
            FrameGapSet_i = gap[15:0];
            if ($urandom_range(2, 0) == 0) begin
                popOne();
                checkAll("rnd.pop");
            end
            nb = $urandom_range(6, 1);
            for (int b = 0; b < nb; b++) begin
                ms  = $urandom_range(999, 0);
                acq = $urandom_range(9, 0);
                sendByte(ms, acq);
                if (b < nb - 1) repeat ($urandom_range(gap - 1, 0)) acqTick();
            end
            repeat (gap - 1) acqTick();
            checkAll("rnd.open");
            acqTick();
            modelClose(infoWord(nb, ms, acq), 1'b0);
            checkAll("rnd.close");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_recorder.md
Name: rx_frame_recorder

Overview:
- Sits directly downstream of the receive core's byte path; observes every byte accepted into the rx data FIFO.
- Splits the byte stream into frames using an idle-gap timeout measured in AcqSig ticks.
- On frame close, pushes one 28-bit frame-info word into an internal FIFO for the CPU/CtrlCore: {byte count, last-byte millisecond stamp, last-byte 0.1 ms stamp}.
- Fills the frame-info port that the receive core leaves unimplemented.

Parameters:
- DEPTH, 8, number of frame-info entries; power of two, 2..64.
- CNT_W, 12, frame byte-count width; frame_info = {count[11:0], ms[11:0], acq[3:0]}.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- p_Enable_i  in  1  block enable; low forces IDLE and discards any open frame
- n_Clr_i  in  1  active-low, 1-clk; empties the info FIFO, aborts any open frame, clears p_FrameOver_o
- p_ByteWr_i  in  1  1-clk pulse when a received byte is written to the rx data FIFO (inverse of the rx FIFO n_we)
- AcqSig_i  in  1  1-clk acquisition tick from the baud generator
- FrameGapSet_i  in  16  idle gap that closes a frame, in AcqSig ticks; 0 is treated as 1
- acqurate_stamp_i  in  4  0.1 ms stamp, range 0..9
- millisecond_stamp_i  in  12  ms stamp, range 0..999
- n_RxFrameInfo_Rd_i  in  1  active-low, 1-clk pop of the info FIFO
- RxFrameInfo_o  out  28  head entry, first-word-fall-through; 0 when empty
- p_RxFrame_Empty_o  out  1  info FIFO empty
- p_RxFrame_Full_o  out  1  info FIFO full
- FrameNum_o  out  7  entries held
- p_FrameOver_o  out  1  sticky: a closed frame was dropped because the FIFO was full

Behaviour:
- Reset values:
  - All outputs 0, except p_RxFrame_Empty_o = 1.
  - FSM state IDLE; ByteCnt = 0; GapCnt = 0; latched stamps = 0.
- FSM, one-hot, 3 states:
  - IDLE -> RECV on p_ByteWr_i while p_Enable_i is high.
  - RECV -> CLOSE when GapCnt reaches max(FrameGapSet_i,1) on an AcqSig_i tick with no p_ByteWr_i in that cycle.
  - CLOSE -> IDLE after exactly 1 clk.
- Byte handling, in IDLE or RECV on p_ByteWr_i:
  - ByteCnt increments; it saturates at 4095 and does not wrap.
  - GapCnt clears to 0.
  - millisecond_stamp_i and acqurate_stamp_i are latched in the same cycle.
  - On the first byte from IDLE, ByteCnt is loaded with 1.
- Gap counting: GapCnt increments on each AcqSig_i in RECV only; it saturates at 0xFFFF.
- CLOSE cycle:
  - Push {ByteCnt, ms_latched, acq_latched} if not full.
  - If full, drop the entry and set p_FrameOver_o.
  - ByteCnt clears to 0.
  - A p_ByteWr_i arriving in the CLOSE cycle starts a new frame: next state RECV, ByteCnt = 1, stamps latched.
- Simultaneous byte and gap expiry: the byte wins; the frame stays open and GapCnt clears.
- Info FIFO:
  - Write-to-visible latency is 1 clk: an entry pushed in CLOSE appears on RxFrameInfo_o the next cycle, with p_RxFrame_Empty_o falling in that same cycle.
  - A pop when empty is ignored.
  - Push and pop in the same cycle when full: both take effect; count is unchanged and no overflow occurs.
  - Push and pop in the same cycle when empty: only the push takes effect.
  - Pointers wrap modulo DEPTH; FrameNum_o ranges 0..DEPTH.
- n_Clr_i:
  - Pointers, count, open frame and p_FrameOver_o all cleared next clk.
  - Has priority over a simultaneous push or pop.
- p_Enable_i low: the FSM goes to IDLE and ByteCnt/GapCnt clear; stored entries are kept.
- Asynchronous reset mid-frame: everything returns to reset values immediately; no partial entry is ever written.

Decomposition:
- Shared package rx_frame_pkg:
  - State encodings ST_IDLE 3'b001, ST_RECV 3'b010, ST_CLOSE 3'b100.
  - Field widths CNT_W/MS_W/ACQ_W.
  - Field offsets of the info word.
- Sub-module frame_info_fifo (DEPTH, WIDTH=28):
  - FWFT register-array FIFO with n_we/n_re/n_clr.
  - Provides count/full/empty.
- Top level holds the FSM, counters and stamp latches.

Test Plan:
- FrameGapSet_i=10; 5 bytes spaced 3 AcqSig apart, last byte at ms=123, acq=7; then silence -> exactly 1 entry 0x005_07B_7 (count 5, ms 0x07B, acq 7) appears 10 ticks after the last byte, and Empty falls.
- Byte pulse in the same cycle as the 10th gap tick -> no entry; the frame continues and the count includes that byte.
- DEPTH=8; close 9 frames with no reads -> Full high, FrameNum_o=8, p_FrameOver_o=1, head still holds frame 1; one n_RxFrameInfo_Rd_i -> head shows frame 2, FrameNum_o=7.
- FIFO full; pop together with a closing frame -> FrameNum_o stays 8 and p_FrameOver_o stays 0.
- 4100 bytes with no gap -> entry count field = 4095.
- Assert rst low mid-frame after 3 bytes, then release and go silent -> no entry; all outputs at reset values. Separately, pulse n_Clr_i with 3 entries stored -> Empty=1, FrameNum_o=0 next clk.
